// File: rtl/imem_loader_if.sv
// Byte-stream input link plus instruction-memory write port of the loader.
//   in_data/in_valid/in_ready : valid/ready byte stream (transfer = in_valid & in_ready)
//   mem_we/mem_addr/mem_wdata : single-cycle write strobe, word address and 16-bit word
// master: stream source / memory observer; slave: the loader itself.
interface imem_loader_if #(
  parameter int unsigned ADDR_W = 8
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;

  modport master (
    output in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction memory loader: takes a byte stream (16-bit word count N, high byte first, then
// N big-endian words) and writes the words to consecutive addresses starting at BASE_ADDR,
// wrapping modulo 2**ADDR_W. The CPU is held in reset (cpu_hold) for the whole load.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : one-cycle pulse, begins a load (only honoured while idle)
//   bus        : imem_loader_if.slave - byte stream in, memory write port out
//   cpu_hold   : high while a load is in progress
//   done       : one-cycle pulse on successful completion
//   err        : sticky error (bad count / bad checksum), cleared by the next accepted start
// Optional feature: define IMEM_LOADER_CSUM_EN to require a trailing checksum byte equal to
// the XOR of all payload bytes.
module imem_loader #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  imem_loader_if.slave  bus,
  output logic          cpu_hold,
  output logic          done,
  output logic          err
);

  localparam logic [ADDR_W-1:0] Base = ADDR_W'(BASE_ADDR);

  typedef enum logic [2:0] {
    StIdle,
    StCntHi,
    StCntLo,
    StWHi,
    StWLo
`ifdef IMEM_LOADER_CSUM_EN
    , StCsum
`endif
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        hi_q, hi_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic        xfer;
  logic [15:0] cnt_word;

  assign bus.in_ready  = (state_q != StIdle);
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign cpu_hold      = hold_q;
  assign done          = done_q;
  assign err           = err_q;

  assign xfer     = bus.in_valid & bus.in_ready;
  assign cnt_word = {hi_q, bus.in_data};

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    hold_d  = hold_q;
    done_d  = 1'b0;
    err_d   = err_q;
`ifdef IMEM_LOADER_CSUM_EN
    csum_d  = csum_q;
`endif

    // Address advances in the cycle the write strobe is visible.
    if (we_q) addr_d = addr_q + ADDR_W'(1);

    unique case (state_q)
      StIdle: begin
        // done_q marks the completion cycle; a start there is deliberately dropped.
        if (start && !done_q) begin
          state_d = StCntHi;
          err_d   = 1'b0;
          addr_d  = Base;
          hold_d  = 1'b1;
`ifdef IMEM_LOADER_CSUM_EN
          csum_d  = 8'd0;
`endif
        end
      end
      StCntHi: begin
        if (xfer) begin
          hi_d    = bus.in_data;
          state_d = StCntLo;
        end
      end
      StCntLo: begin
        if (xfer) begin
          if (cnt_word == 16'd0 || 32'(cnt_word) > (32'd1 << ADDR_W)) begin
            err_d   = 1'b1;
            hold_d  = 1'b0;
            state_d = StIdle;
          end else begin
            cnt_d   = cnt_word;
            state_d = StWHi;
          end
        end
      end
      StWHi: begin
        if (xfer) begin
          hi_d    = bus.in_data;
          state_d = StWLo;
`ifdef IMEM_LOADER_CSUM_EN
          csum_d  = csum_q ^ bus.in_data;
`endif
        end
      end
      StWLo: begin
        if (xfer) begin
          wdata_d = {hi_q, bus.in_data};
          we_d    = 1'b1;
          cnt_d   = cnt_q - 16'd1;
`ifdef IMEM_LOADER_CSUM_EN
          csum_d  = csum_q ^ bus.in_data;
`endif
          if (cnt_q == 16'd1) begin
`ifdef IMEM_LOADER_CSUM_EN
            state_d = StCsum;
`else
            state_d = StIdle;
            done_d  = 1'b1;
            hold_d  = 1'b0;
`endif
          end else begin
            state_d = StWHi;
          end
        end
      end
`ifdef IMEM_LOADER_CSUM_EN
      StCsum: begin
        if (xfer) begin
          if (bus.in_data == csum_q) done_d = 1'b1;
          else                       err_d  = 1'b1;
          hold_d  = 1'b0;
          state_d = StIdle;
        end
      end
`endif
      default: begin
        state_d = StIdle;
        hold_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      hi_q    <= 8'd0;
      cnt_q   <= 16'd0;
      addr_q  <= Base;
      wdata_q <= 16'd0;
      we_q    <= 1'b0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
      csum_q  <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef IMEM_LOADER_CSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: two instances (BASE_ADDR 0 and 0xFE) share one byte stream; expected
// writes are queued per instance as words are sent and popped on each mem_we.
module tb_imem_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic in_valid = 1'b0;

  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_W(8)) bus0 ();
  imem_loader_if #(.ADDR_W(8)) bus1 ();

  assign bus0.in_data  = in_data;
  assign bus0.in_valid = in_valid;
  assign bus1.in_data  = in_data;
  assign bus1.in_valid = in_valid;

  logic hold0, done0, err0, hold1, done1, err1;

  imem_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus0.slave),
    .cpu_hold(hold0), .done(done0), .err(err0)
  );

  imem_loader #(.ADDR_W(8), .BASE_ADDR(254)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus1.slave),
    .cpu_hold(hold1), .done(done1), .err(err1)
  );

  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] data;
    logic        last;
  } wr_t;

  wr_t q0[$];
  wr_t q1[$];
  logic [15:0] wq[$];
  int nchk = 0;
  int nerr = 0;
  int ndone0 = 0;
  int ndone1 = 0;

`ifdef IMEM_LOADER_CSUM_EN
  localparam bit CsumEn = 1'b1;
`else
  localparam bit CsumEn = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write monitor / scoreboard
  always @(negedge clk) begin
    wr_t e;
    if (done0) ndone0++;
    if (done1) ndone1++;
    if (bus0.mem_we) begin
      if (q0.size() == 0) begin
        check("unexp_we0", 1, 0);
      end else begin
        e = q0.pop_front();
        check("addr0", {24'd0, bus0.mem_addr}, {24'd0, e.addr});
        check("data0", {16'd0, bus0.mem_wdata}, {16'd0, e.data});
        check("done_at_we0", {31'd0, done0}, {31'd0, e.last & ~CsumEn});
        check("hold_at_we0", {31'd0, hold0}, {31'd0, ~(e.last & ~CsumEn)});
      end
    end
    if (bus1.mem_we) begin
      if (q1.size() == 0) begin
        check("unexp_we1", 1, 0);
      end else begin
        e = q1.pop_front();
        check("addr1", {24'd0, bus1.mem_addr}, {24'd0, e.addr});
        check("data1", {16'd0, bus1.mem_wdata}, {16'd0, e.data});
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n;
    if (gap && $urandom_range(0, 1) == 1) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      repeat ($urandom_range(1, 4)) @(posedge clk);
      #1;
    end
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (!bus0.in_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 50) begin
      check("ready_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Runs one load of the words in wq with count field n_cnt.
  task automatic run_load(input int unsigned n_cnt, input bit gaps, input bit mid_start,
                          input bit bad_csum);
    int d0, d1, n;
    logic [7:0] cs;
    logic [15:0] w;
    bit ok, exp_err;
    d0 = ndone0;
    d1 = ndone1;
    cs = 8'd0;
    ok = (n_cnt != 0) && (n_cnt <= 256);
    pulse_start();
    check("hold_after_start", {31'd0, hold0}, 1);
    check("err_clr_on_start", {31'd0, err0}, 0);
    send_byte(n_cnt[15:8], gaps);
    send_byte(n_cnt[7:0], gaps);
    if (!ok) begin
      @(posedge clk);
      #1;
      check("err_bad_count", {31'd0, err0}, 1);
      check("hold_bad_count", {31'd0, hold0}, 0);
      check("ready_bad_count", {31'd0, bus0.in_ready}, 0);
      repeat (3) @(posedge clk);
      #1;
      check("no_done_bad_count", ndone0 - d0, 0);
      return;
    end
    for (int i = 0; i < wq.size(); i++) begin
      w = wq[i];
      q0.push_back('{addr: 8'(i), data: w, last: (i == wq.size() - 1)});
      q1.push_back('{addr: 8'(254 + i), data: w, last: (i == wq.size() - 1)});
      cs = cs ^ w[15:8] ^ w[7:0];
      send_byte(w[15:8], gaps);
      send_byte(w[7:0], gaps);
      if (mid_start && i == 0) pulse_start();
    end
    if (CsumEn) send_byte(cs ^ {7'd0, bad_csum}, gaps);
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || hold0) && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    exp_err = CsumEn & bad_csum;
    check("drain0", q0.size(), 0);
    check("drain1", q1.size(), 0);
    check("done_count0", ndone0 - d0, exp_err ? 0 : 1);
    check("done_count1", ndone1 - d1, exp_err ? 0 : 1);
    check("err_end", {31'd0, err0}, {31'd0, exp_err});
    check("hold_end", {31'd0, hold0}, 0);
    // Surplus bytes must not be taken
    in_data  = 8'hAA;
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("ready_after_done", {31'd0, bus0.in_ready}, 0);
    in_valid = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, bus0.in_ready}, 0);
    check("rst_we", {31'd0, bus0.mem_we}, 0);
    check("rst_hold", {31'd0, hold0}, 0);
    check("rst_done", {31'd0, done0}, 0);
    check("rst_err", {31'd0, err0}, 0);
    check("rst_addr0", {24'd0, bus0.mem_addr}, 0);
    check("rst_addr1", {24'd0, bus1.mem_addr}, 32'hFE);
    check("rst_wdata", {16'd0, bus0.mem_wdata}, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic two-word load
    wq = '{16'h8040, 16'h8081};
    run_load(2, 1'b0, 1'b0, 1'b0);

    // Zero count, then the next start clears err
    wq = '{};
    run_load(0, 1'b0, 1'b0, 1'b0);
    wq = '{16'h1111};
    run_load(1, 1'b0, 1'b0, 1'b0);

    // Over-size count, then full-depth load
    wq = '{};
    run_load(257, 1'b0, 1'b0, 1'b0);
    wq = '{};
    for (int i = 0; i < 256; i++) wq.push_back(16'($urandom));
    run_load(256, 1'b0, 1'b0, 1'b0);

    // Three words: wraps 0xFE, 0xFF, 0x00 on the offset instance
    wq = '{16'hA5A5, 16'h0F0F, 16'h1357};
    run_load(3, 1'b1, 1'b0, 1'b0);

    // Gapped stream with a stray start mid-load
    wq = '{16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D};
    run_load(4, 1'b1, 1'b1, 1'b0);

    // Checksum-sized single word, good and bad trailer (trailer only sent when enabled)
    wq = '{16'h0280};
    run_load(1, 1'b0, 1'b0, 1'b0);
    run_load(1, 1'b0, 1'b0, 1'b1);

    // Reset after the first word of a load
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h04, 1'b0);
    q0.push_back('{addr: 8'h00, data: 16'h1234, last: 1'b0});
    q1.push_back('{addr: 8'hFE, data: 16'h1234, last: 1'b0});
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    send_byte(8'h56, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", {31'd0, bus0.in_ready}, 0);
    check("mid_rst_we", {31'd0, bus0.mem_we}, 0);
    check("mid_rst_hold", {31'd0, hold0}, 0);
    check("mid_rst_done", {31'd0, done0}, 0);
    check("mid_rst_err", {31'd0, err0}, 0);
    check("mid_rst_addr0", {24'd0, bus0.mem_addr}, 0);
    check("mid_rst_addr1", {24'd0, bus1.mem_addr}, 32'hFE);
    check("mid_rst_wdata", {16'd0, bus0.mem_wdata}, 0);
    check("mid_rst_drain", q0.size(), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    in_data  = 8'h78;
    in_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("post_rst_ready", {31'd0, bus0.in_ready}, 0);
    check("post_rst_hold", {31'd0, hold0}, 0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
